// File: rtl/press_recorder.sv
// press_recorder: captures Simon Says player presses into a sequence memory.
// Each stored word is {gap[IDX_W-3:0], code[1:0]}. Here gap is the number of
// RECORD cycles since the previous accepted press (or since start). The gap
// saturates at all-ones. The checker reads entries back through a registered
// read port.
module press_recorder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   target_len,
  input  logic [3:0]        btn,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [IDX_W-1:0]  rd_data,
  output logic [ADDR_W:0]   rec_count,
  output logic              busy,
  output logic              done,
  output logic              press_valid,
  output logic [1:0]        press_code,
  output logic              err_multi
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-3:0] GAP_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [3:0]        btn_q;
  logic [ADDR_W:0]   rec_count_q, rec_count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [IDX_W-3:0]  gap_q, gap_d;
  logic              press_valid_q, press_valid_d;
  logic [1:0]        press_code_q, press_code_d;
  logic              err_multi_q, err_multi_d;
  logic [IDX_W-1:0]  rd_data_q;
  logic [IDX_W-1:0]  mem_q [DEPTH];

  logic [3:0]        rise;
  logic              in_rec;
  logic              one_hot;
  logic              accept;
  logic              reject;
  logic [1:0]        code;
  logic [ADDR_W:0]   count_inc;

  // Map a one-hot rising-edge vector to its 2-bit button code
  function automatic logic [1:0] encode_btn(input logic [3:0] r);
    logic [1:0] c;
    c = 2'd0;
    if (r[1]) c = 2'd1;
    if (r[2]) c = 2'd2;
    if (r[3]) c = 2'd3;
    return c;
  endfunction

  assign rise      = btn & ~btn_q;
  assign in_rec    = (state_q == S_RECORD);
  assign one_hot   = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
  // start wins over a coincident press, so the press is neither stored nor flagged
  assign accept    = in_rec && !start && one_hot && (btn == rise);
  assign reject    = in_rec && !start && (rise != 4'd0) && !accept;
  assign code      = encode_btn(rise);
  assign count_inc = rec_count_q + 1'b1;

  // Next-state logic for the FSM, counters and press/error flags
  always_comb begin
    state_d       = state_q;
    rec_count_d   = rec_count_q;
    len_d         = len_q;
    gap_d         = gap_q;
    press_valid_d = accept;
    press_code_d  = accept ? code : press_code_q;
    err_multi_d   = reject;
    if (start) begin
      rec_count_d = '0;
      gap_d       = '0;
      len_d       = (target_len > DEPTH_C) ? DEPTH_C : target_len;
      state_d     = (target_len == '0) ? S_DONE : S_RECORD;
    end else if (in_rec) begin
      if (accept) begin
        rec_count_d = count_inc;
        gap_d       = '0;
      end else if (gap_q != GAP_MAX) begin
        gap_d = gap_q + 1'b1;
      end
      // A press coinciding with stop is still stored before leaving RECORD
      if ((accept && (count_inc == len_q)) || stop) begin
        state_d = S_DONE;
      end
    end
  end

  // Control and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      btn_q         <= 4'd0;
      rec_count_q   <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      press_valid_q <= 1'b0;
      press_code_q  <= 2'd0;
      err_multi_q   <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn;
      rec_count_q   <= rec_count_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      press_valid_q <= press_valid_d;
      press_code_q  <= press_code_d;
      err_multi_q   <= err_multi_d;
      rd_data_q     <= mem_q[rd_addr];
    end
  end

  // Sequence memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[rec_count_q[ADDR_W-1:0]] <= {gap_q, code};
    end
  end

  assign rd_data     = rd_data_q;
  assign rec_count   = rec_count_q;
  assign busy        = (state_q == S_RECORD);
  assign done        = (state_q == S_DONE);
  assign press_valid = press_valid_q;
  assign press_code  = press_code_q;
  assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_press_recorder.sv
// Testbench for press_recorder: a table of cycle-by-cycle vectors, followed by
// hand-written sequences for the multi-cycle corner cases.
module tb_press_recorder;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        stop;
  logic [8:0]  target_len;
  logic [3:0]  btn;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;
  logic [8:0]  rec_count;
  logic        busy;
  logic        done;
  logic        press_valid;
  logic [1:0]  press_code;
  logic        err_multi;

  int checks;
  int failures;

  typedef struct {
    logic        st;
    logic        sp;
    logic [8:0]  tl;
    logic [3:0]  b;
    logic [7:0]  addr;
    logic        busy;
    logic        done;
    logic [8:0]  cnt;
    logic        pv;
    logic [1:0]  code;
    logic        err;
    logic        ck_rd;
    logic [11:0] rd;
  } vec_t;

  vec_t vt[$];

  press_recorder dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .stop       (stop),
    .target_len (target_len),
    .btn        (btn),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rec_count  (rec_count),
    .busy       (busy),
    .done       (done),
    .press_valid(press_valid),
    .press_code (press_code),
    .err_multi  (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic sp, input logic [8:0] tl, input logic [3:0] b,
                     input logic [7:0] addr, input logic bz, input logic dn, input logic [8:0] cnt,
                     input logic pv, input logic [1:0] code, input logic err,
                     input logic ck, input logic [11:0] rd);
    vec_t v;
    v.st = st; v.sp = sp; v.tl = tl; v.b = b; v.addr = addr;
    v.busy = bz; v.done = dn; v.cnt = cnt; v.pv = pv; v.code = code; v.err = err;
    v.ck_rd = ck; v.rd = rd;
    vt.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic [8:0] tl,
                       input logic [3:0] b, input logic [7:0] addr);
    start = st; stop = sp; target_len = tl; btn = b; rd_addr = addr;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_rst = 1'b0;
    drive(0, 0, 0, 4'b0000, 0);

    // Basic record: three presses, target 3, then readback and a press in DONE
    add(1,0,3,4'b0000,0, 1,0,0,0,0,0, 0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,4'b0000,0, 1,0,0,0,0,0, 0,0);
    add(0,0,0,4'b0001,0, 1,0,1,1,0,0, 0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,4'b0000,0, 1,0,1,0,0,0, 0,0);
    add(0,0,0,4'b0100,0, 1,0,2,1,2,0, 0,0);
    add(0,0,0,4'b0000,0, 1,0,2,0,2,0, 0,0);
    add(0,0,0,4'b1000,0, 0,1,3,1,3,0, 0,0);
    add(0,0,0,4'b0000,0, 0,1,3,0,3,0, 1,12'h010);
    add(0,0,0,4'b0000,1, 0,1,3,0,3,0, 1,12'h016);
    add(0,0,0,4'b0000,2, 0,1,3,0,3,0, 1,12'h007);
    add(0,0,0,4'b0001,0, 0,1,3,0,3,0, 1,12'h010);
    add(0,0,0,4'b0000,0, 0,1,3,0,3,0, 0,0);
    // Held button and multi-button rejection, then early stop
    add(1,0,5,4'b0000,0, 1,0,0,0,3,0, 0,0);
    add(0,0,0,4'b0010,0, 1,0,1,1,1,0, 0,0);
    add(0,0,0,4'b0010,0, 1,0,1,0,1,0, 0,0);
    add(0,0,0,4'b0010,0, 1,0,1,0,1,0, 1,12'h001);
    for (int i = 0; i < 7; i++) add(0,0,0,4'b0010,0, 1,0,1,0,1,0, 0,0);
    add(0,0,0,4'b0000,0, 1,0,1,0,1,0, 0,0);
    add(0,0,0,4'b0011,0, 1,0,1,0,1,1, 0,0);
    add(0,0,0,4'b0000,0, 1,0,1,0,1,0, 0,0);
    add(0,0,0,4'b0001,0, 1,0,2,1,0,0, 0,0);
    add(0,0,0,4'b0001,0, 1,0,2,0,0,0, 0,0);
    add(0,0,0,4'b0011,0, 1,0,2,0,0,1, 0,0);
    add(0,0,0,4'b0000,1, 1,0,2,0,0,0, 1,12'h030);
    add(0,1,0,4'b0000,0, 0,1,2,0,0,0, 0,0);

    // Reset state
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cnt", rec_count, 0);
    check("reset_pv", press_valid, 0);
    n_rst = 1'b1;
    tick();

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].sp, vt[i].tl, vt[i].b, vt[i].addr);
      tick();
      check($sformatf("v%0d_busy", i), busy, vt[i].busy);
      check($sformatf("v%0d_done", i), done, vt[i].done);
      check($sformatf("v%0d_cnt", i), rec_count, vt[i].cnt);
      check($sformatf("v%0d_pv", i), press_valid, vt[i].pv);
      check($sformatf("v%0d_code", i), press_code, vt[i].code);
      check($sformatf("v%0d_err", i), err_multi, vt[i].err);
      if (vt[i].ck_rd) check($sformatf("v%0d_rd", i), rd_data, vt[i].rd);
    end

    // stop coinciding with an accepted press: stored, counted, then DONE
    drive(1, 0, 5, 4'b0000, 0); tick();
    drive(0, 1, 0, 4'b0100, 0); tick();
    check("stoppress_cnt", rec_count, 1);
    check("stoppress_done", done, 1);
    check("stoppress_pv", press_valid, 1);
    check("stoppress_code", press_code, 2);
    drive(0, 0, 0, 4'b0000, 0); tick();
    check("stoppress_rd", rd_data, 12'h002);

    // start in RECORD with a rising button: start wins
    drive(1, 0, 5, 4'b0000, 0); tick();
    drive(0, 0, 0, 4'b0000, 0); tick();
    drive(1, 0, 5, 4'b0001, 0); tick();
    check("startpress_cnt", rec_count, 0);
    check("startpress_pv", press_valid, 0);
    check("startpress_busy", busy, 1);
    drive(0, 0, 0, 4'b0001, 0); tick();
    check("startheld_pv", press_valid, 0);
    check("startheld_cnt", rec_count, 0);
    drive(0, 0, 0, 4'b0000, 0); tick();

    // target_len = 0 goes straight to DONE
    drive(1, 0, 0, 4'b0000, 0); tick();
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);

    // Gap saturation
    drive(1, 0, 4, 4'b0000, 0); tick();
    drive(0, 0, 0, 4'b0000, 0);
    repeat (2000) tick();
    drive(0, 0, 0, 4'b0100, 0); tick();
    check("sat_pv", press_valid, 1);
    drive(0, 0, 0, 4'b0000, 0); tick();
    check("sat_rd", rd_data, 12'hFFE);

    // Asynchronous reset mid-RECORD
    drive(0, 0, 0, 4'b0001, 0); tick();
    check("prereset_pv", press_valid, 1);
    #2 n_rst = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_cnt", rec_count, 0);
    check("async_pv", press_valid, 0);
    check("async_code", press_code, 0);
    check("async_rd", rd_data, 0);
    check("async_done", done, 0);
    #1 n_rst = 1'b1;
    drive(0, 0, 0, 4'b0000, 0); tick();
    drive(0, 0, 0, 4'b0001, 0); tick();
    check("idle_pv", press_valid, 0);
    tick();
    check("idle_cnt", rec_count, 0);
    check("idle_busy", busy, 0);
    drive(0, 0, 0, 4'b0000, 0); tick();

    // Clamp: target 300 records at most 256 presses
    drive(1, 0, 300, 4'b0000, 0); tick();
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 0, 4'b0001, 0); tick();
      if (i == 254) begin
        check("clamp_cnt255", rec_count, 255);
        check("clamp_busy255", busy, 1);
      end
      drive(0, 0, 0, 4'b0000, 0); tick();
    end
    check("clamp_cnt", rec_count, 256);
    check("clamp_done", done, 1);
    drive(0, 0, 0, 4'b0001, 0); tick();
    check("clamp_nopv", press_valid, 0);
    check("clamp_hold", rec_count, 256);
    drive(0, 0, 0, 4'b0000, 255); tick();
    check("clamp_rd255", rd_data, 12'h004);
    drive(0, 0, 0, 4'b0000, 0); tick();
    check("clamp_rd0", rd_data, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
